store_commit_buffer: RTL

- Sits between the LSU store path and the data-cache write port.
- Holds executed stores in program order; each store stays speculative until the commit stage retires it via fireStore/fireStore1.
- Retired stores drain in order to memory with a valid/ready handshake.
- A pipeline flush discards all still-speculative entries and keeps retired ones.

---
 rtl/store_commit_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/store_commit_buffer.sv
// In-order store commit buffer between the LSU store path and the data-cache write port.
// Optional same-cycle store-to-load forwarding is built when STORE_LOAD_FWD_EN is defined.
module store_commit_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_addr,
  input  logic [31:0]      enq_data,
  input  logic [1:0]       enq_size,
  output logic             enq_ready,
  input  logic             fire_store,
  input  logic             fire_store1,
  output logic             mem_req_valid,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  output logic [3:0]       mem_req_be,
  input  logic             mem_req_ready,
  output logic             drained,
  output logic [PTR_W-1:0] spec_cnt,
  input  logic [31:0]      ld_addr,
  output logic             ld_fwd_hit,
  output logic [31:0]      ld_fwd_data,
  output logic [3:0]       ld_fwd_be
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // head..cmt are retired, cmt..tail are speculative; MSB is the wrap bit
  logic [PTR_W-1:0] head, cmt, tail;
  logic [PTR_W-1:0] head_nxt, cmt_nxt, tail_nxt;
  logic [PTR_W-1:0] occupancy, fire_req, cmt_adv;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             enq_fire, drain_fire;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic             unused_ld;

  logic [29:0]      ent_addr  [DEPTH];
  logic [31:0]      ent_wdata [DEPTH];
  logic [3:0]       ent_be    [DEPTH];

  assign occupancy     = tail - head;
  assign spec_cnt      = tail - cmt;
  assign enq_ready     = (occupancy != PTR_W'(DEPTH));
  assign drained       = (head == cmt);
  assign mem_req_valid = !drained;
  assign head_idx      = head[IDX_W-1:0];
  assign tail_idx      = tail[IDX_W-1:0];
  assign enq_fire      = enq_valid && enq_ready && !flush;
  assign drain_fire    = mem_req_valid && mem_req_ready;

  // Retire count is clamped to the speculative population so cmt never passes tail
  assign fire_req = PTR_W'(fire_store) + PTR_W'(fire_store1);
  assign cmt_adv  = (fire_req > spec_cnt) ? spec_cnt : fire_req;

  // Head entry is presented directly; zeroed while nothing is retired
  assign mem_req_addr  = mem_req_valid ? {ent_addr[head_idx], 2'b00} : 32'h0;
  assign mem_req_wdata = mem_req_valid ? ent_wdata[head_idx] : 32'h0;
  assign mem_req_be    = mem_req_valid ? ent_be[head_idx] : 4'h0;

  // Lane placement of the raw register value; size 3 never arrives and falls back to word
  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = enq_data;
    case (enq_size)
      2'd0: begin
        fmt_be    = 4'b0001 << enq_addr[1:0];
        fmt_wdata = {4{enq_data[7:0]}};
      end
      2'd1: begin
        fmt_be    = enq_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{enq_data[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = enq_data;
      end
    endcase
  end

  // Flush rewinds tail onto the post-commit cmt, discarding speculative work
  always_comb begin
    head_nxt = head;
    cmt_nxt  = cmt + cmt_adv;
    tail_nxt = tail;
    if (drain_fire) begin
      head_nxt = head + PTR_W'(1);
    end
    if (flush) begin
      tail_nxt = cmt_nxt;
    end else if (enq_fire) begin
      tail_nxt = tail + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      cmt  <= cmt_nxt;
      tail <= tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      ent_addr[tail_idx]  <= enq_addr[31:2];
      ent_wdata[tail_idx] <= fmt_wdata;
      ent_be[tail_idx]    <= fmt_be;
    end
  end

`ifdef STORE_LOAD_FWD_EN
  logic [IDX_W-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest matching entry wins
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = 32'h0;
    ld_fwd_be   = 4'h0;
    fwd_idx     = head_idx;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_idx + IDX_W'(k);
      if ((PTR_W'(k) < occupancy) && (ent_addr[fwd_idx] == ld_addr[31:2])) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = ent_wdata[fwd_idx];
        ld_fwd_be   = ent_be[fwd_idx];
      end
    end
  end

  assign unused_ld = ^ld_addr[1:0];
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = 32'h0;
  assign ld_fwd_be   = 4'h0;
  assign unused_ld   = ^ld_addr;
`endif

  // Commit must never retire more stores than are speculative
  commit_within_tail: assert property (@(posedge clk) disable iff (rst) fire_req <= spec_cnt);

endmodule
